// File: rtl/majority_pkg.sv
// Shared constants and width helpers for the majority voter slice.
package majority_pkg;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_THRESH = 1'b1;

  // Bits needed to hold any value in 0..n.
  function automatic int clog2_plus1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/majority_popcount.sv
// Combinational popcount of a WIDTH-bit word as a balanced pairwise adder tree.
module majority_popcount #(
  parameter int WIDTH = 7,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] count
);

  // Leaves padded to a power of two so every tree level pairs cleanly.
  localparam int LEAVES = 1 << $clog2(WIDTH);

  logic [LEAVES-1:0] padded;
  logic [CNT_W-1:0]  node [LEAVES];

  always_comb begin
    padded = LEAVES'(word);
    for (int i = 0; i < LEAVES; i++) node[i] = CNT_W'(padded[i]);
    for (int s = LEAVES / 2; s >= 1; s = s / 2)
      for (int i = 0; i < s; i++) node[i] = node[2*i] + node[2*i+1];
    count = node[0];
  end

endmodule

// File: rtl/majority_window_voter.sv
// Registered spatial majority voter with a sliding-window temporal majority.
module majority_window_voter
  import majority_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = clog2_plus1(WIDTH),
  parameter int WCNT_W = clog2_plus1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              mode,
  input  logic [CNT_W-1:0]  thr,
  input  logic              clear,
  output logic              out_valid,
  output logic [CNT_W-1:0]  pop_cnt,
  output logic              maj_out,
  output logic [WCNT_W-1:0] win_cnt,
  output logic              win_full,
  output logic              win_maj
);

  logic [CNT_W-1:0]  pop;
  logic              sbit;
  logic [DEPTH-1:0]  win_sr;
  logic [WCNT_W-1:0] fill, fill_next, cnt_next;
  logic [WCNT_W:0]   cnt_wide;
  logic              oldest, full_next;

  majority_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pop (
    .word  (in_data),
    .count (pop)
  );

  always_comb begin
    if (mode == MODE_STRICT) sbit = (2 * int'(pop)) > WIDTH;
    else                     sbit = (pop >= thr);
  end

  assign win_full = (fill == WCNT_W'(DEPTH));
  assign oldest   = win_full & win_sr[DEPTH-1];

  // Running sum: one spare bit so the +bit never wraps before the -oldest.
  always_comb begin
    cnt_wide  = {1'b0, win_cnt} + (WCNT_W+1)'(sbit) - (WCNT_W+1)'(oldest);
    cnt_next  = cnt_wide[WCNT_W-1:0];
    fill_next = win_full ? fill : fill + 1'b1;
    full_next = (fill_next == WCNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pop_cnt   <= '0;
      maj_out   <= 1'b0;
      win_sr    <= '0;
      fill      <= '0;
      win_cnt   <= '0;
      win_maj   <= 1'b0;
    end else begin
      out_valid <= in_valid & ~clear;
      if (clear) begin
        win_sr  <= '0;
        fill    <= '0;
        win_cnt <= '0;
        win_maj <= 1'b0;
      end else if (in_valid) begin
        pop_cnt <= pop;
        maj_out <= sbit;
        win_sr  <= (win_sr << 1) | DEPTH'(sbit);
        fill    <= fill_next;
        win_cnt <= cnt_next;
        win_maj <= full_next && ((2 * int'(cnt_next)) > DEPTH);
      end
    end
  end

endmodule

// File: tb/tb_majority_window_voter.sv
// Directed bench for majority_window_voter at WIDTH=7, DEPTH=4.
module tb_majority_window_voter;

  localparam int WIDTH  = 7;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int WCNT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              mode = 1'b0;
  logic [CNT_W-1:0]  thr = '0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic [CNT_W-1:0]  pop_cnt;
  logic              maj_out;
  logic [WCNT_W-1:0] win_cnt;
  logic              win_full;
  logic              win_maj;

  int n_assert = 0;
  int n_fail   = 0;

  majority_window_voter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .thr(thr), .clear(clear), .out_valid(out_valid),
    .pop_cnt(pop_cnt), .maj_out(maj_out), .win_cnt(win_cnt),
    .win_full(win_full), .win_maj(win_maj)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ov, input int pc, input int mo,
                         input int wc, input int wf, input int wm);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".pop_cnt"},   32'(pop_cnt),   32'(pc));
    chk({tag, ".maj_out"},   32'(maj_out),   32'(mo));
    chk({tag, ".win_cnt"},   32'(win_cnt),   32'(wc));
    chk({tag, ".win_full"},  32'(win_full),  32'(wf));
    chk({tag, ".win_maj"},   32'(win_maj),   32'(wm));
  endtask

  initial begin
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Stream 99,28,119,101,32,48,75
    step(1, 7'd99, 0);  chk_all("s1", 1, 4, 1, 1, 0, 0);
    step(1, 7'd28, 0);  chk_all("s2", 1, 3, 0, 1, 0, 0);
    step(1, 7'd119, 0); chk_all("s3", 1, 6, 1, 2, 0, 0);
    step(1, 7'd101, 0); chk_all("s4", 1, 4, 1, 3, 1, 1);
    step(1, 7'd32, 0);  chk_all("s5", 1, 1, 0, 2, 1, 0);
    step(1, 7'd48, 0);  chk_all("s6", 1, 2, 0, 2, 1, 0);
    step(1, 7'd75, 0);  chk_all("s7", 1, 4, 1, 2, 1, 0);
    step(0, 7'd0, 0);   chk_all("idle0", 0, 4, 1, 2, 1, 0);

    // Flush, then accept with idle gaps
    step(0, 7'd0, 1);   chk_all("flush", 0, 4, 1, 0, 0, 0);
    step(1, 7'd99, 0);  chk_all("g1", 1, 4, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 7'd127, 0); chk_all("gidle", 0, 4, 1, 1, 0, 0);
    end
    step(1, 7'd28, 0);  chk_all("g2", 1, 3, 0, 1, 0, 0);
    step(1, 7'd119, 0); chk_all("g3", 1, 6, 1, 2, 0, 0);
    step(1, 7'd101, 0); chk_all("g4", 1, 4, 1, 3, 1, 1);

    // Clear beats a simultaneous accept
    step(1, 7'd119, 1); chk_all("clr_acc", 0, 4, 1, 0, 0, 0);
    step(1, 7'd119, 0); chk_all("post_clr", 1, 6, 1, 1, 0, 0);

    // Threshold mode
    mode = 1'b1;
    thr = 3'd5; step(1, 7'd119, 0);  chk_all("t119", 1, 6, 1, 2, 0, 0);
    thr = 3'd5; step(1, 7'd101, 0);  chk_all("t101", 1, 4, 0, 2, 0, 0);
    thr = 3'd0; step(1, 7'd0, 0);    chk_all("t0", 1, 0, 1, 3, 1, 1);
    thr = 3'd7; step(1, 7'h7F, 0);   chk_all("t7F", 1, 7, 1, 3, 1, 1);
    thr = 3'd7; step(1, 7'h7E, 0);   chk_all("t7E", 1, 6, 0, 2, 1, 0);
    mode = 1'b0; thr = 3'd0;
    step(1, 7'd119, 0); chk_all("refill", 1, 6, 1, 3, 1, 1);

    // Asynchronous reset between edges
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    step(1, 7'd119, 0); chk_all("r1", 1, 6, 1, 1, 0, 0);
    step(1, 7'd119, 0); chk_all("r2", 1, 6, 1, 2, 0, 0);
    step(1, 7'd119, 0); chk_all("r3", 1, 6, 1, 3, 0, 0);
    step(1, 7'd119, 0); chk_all("r4", 1, 6, 1, 4, 1, 1);
    step(0, 7'd0, 0);   chk_all("end", 0, 6, 1, 4, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
